// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: ROB tag width, ALU-class
// opcodes, the per-entry storage layout and the broadcast snoop helper.
// Optional feature macro used by the RS files: ALU_RS_OLDEST_FIRST_EN.
package alu_rs_pkg;

    localparam int ROB_TAG_W = 4;

    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
    localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [6:0] OPCODE_BR     = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    // One source operand: either a value (rdy=1) or the ROB tag of its producer.
    typedef struct packed {
        logic [31:0]          val;
        logic                 rdy;
        logic [ROB_TAG_W-1:0] tag;
    } rs_op_t;

    typedef struct packed {
        logic                 busy;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_TAG_W-1:0] rob_pos;
        rs_op_t               op1;
        rs_op_t               op2;
    } rs_entry_t;

    // Capture a broadcast value into a waiting operand. The ALU bus is checked
    // first so it wins if both buses (illegally) carry the same tag.
    function automatic rs_op_t snoop(
        input rs_op_t               op,
        input logic                 a_v,
        input logic [ROB_TAG_W-1:0] a_tag,
        input logic [31:0]          a_val,
        input logic                 l_v,
        input logic [ROB_TAG_W-1:0] l_tag,
        input logic [31:0]          l_val
    );
        rs_op_t r;
        r = op;
        if (!op.rdy) begin
            if (a_v && (a_tag == op.tag)) begin
                r.val = a_val;
                r.rdy = 1'b1;
            end else if (l_v && (l_tag == op.tag)) begin
                r.val = l_val;
                r.rdy = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Priority picker shared by reservation stations: returns the lowest set index
// of a request vector, or, with ALU_RS_OLDEST_FIRST_EN defined, the request
// with the largest age (lower index on ties).
module rs_select #(
    parameter int  N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
`ifdef ALU_RS_OLDEST_FIRST_EN
    input  logic [N*IW-1:0] age,
`endif
    output logic            found,
    output logic [IW-1:0]   idx
);

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [IW-1:0] best_age;

    // Scan upward; a strictly larger age is needed to displace a lower index.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        best_age = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (!found || (age[i*IW +: IW] > best_age))) begin
                found    = 1'b1;
                idx      = IW'(i);
                best_age = age[i*IW +: IW];
            end
        end
    end
`else
    // Fixed priority: the first set bit from index 0 wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU-class instructions, wakes
// operands from the ALU/LSB result buses and issues one ready entry per cycle.
// Optional feature macro: ALU_RS_OLDEST_FIRST_EN (oldest-first selection).
//
// Handshakes: the dispatcher asserts issue_valid only while rs_full is low; a
// transfer happens at a clock edge with rdy high. Result broadcasts are
// single-cycle valid pulses with no back-pressure. alu_en is a one-cycle
// strobe towards the ALU, which always accepts; there is no ready return.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = ROB_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue_valid,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7,
    input  logic [31:0]          issue_rs1_val,
    input  logic                 issue_rs1_rdy,
    input  logic [ROB_POS_W-1:0] issue_rs1_tag,
    input  logic [31:0]          issue_rs2_val,
    input  logic                 issue_rs2_rdy,
    input  logic [ROB_POS_W-1:0] issue_rs2_tag,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rs_full,
    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [31:0]          alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [31:0]          lsb_result_val,
    output logic                 alu_en,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic                 funct7,
    output logic [31:0]          val1,
    output logic [31:0]          val2,
    output logic [31:0]          imm,
    output logic [31:0]          pc,
    output logic [ROB_POS_W-1:0] rob_pos
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t          ent [RS_SIZE];
    rs_entry_t          new_ent;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] elig_vec;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               do_issue;
    logic               flush;

    // Busy and eligibility vectors from the state at the start of the cycle.
    always_comb begin
        busy_vec = '0;
        elig_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = ent[i].busy;
            elig_vec[i] = ent[i].busy && ent[i].op1.rdy && ent[i].op2.rdy;
        end
    end

    assign rs_full  = &busy_vec;
    assign do_issue = issue_valid && !rs_full && free_found;
    assign flush    = rst || (rdy && rollback);

    // Incoming entry, with the same-cycle broadcast bypass applied.
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.opcode  = issue_opcode;
        new_ent.funct3  = issue_funct3;
        new_ent.funct7  = issue_funct7;
        new_ent.imm     = issue_imm;
        new_ent.pc      = issue_pc;
        new_ent.rob_pos = issue_rob_pos;
        new_ent.op1     = snoop('{val: issue_rs1_val, rdy: issue_rs1_rdy, tag: issue_rs1_tag},
                                alu_result, alu_result_rob_pos, alu_result_val,
                                lsb_result, lsb_result_rob_pos, lsb_result_val);
        new_ent.op2     = snoop('{val: issue_rs2_val, rdy: issue_rs2_rdy, tag: issue_rs2_tag},
                                alu_result, alu_result_rob_pos, alu_result_val,
                                lsb_result, lsb_result_rob_pos, lsb_result_val);
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [IDX_W-1:0]         age [RS_SIZE];
    logic [RS_SIZE*IDX_W-1:0] age_flat;

    // Flatten the per-entry ages for the picker.
    always_comb begin
        age_flat = '0;
        for (int i = 0; i < RS_SIZE; i++) age_flat[i*IDX_W +: IDX_W] = age[i];
    end

    // Ages count how many later instructions have been issued, saturating.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (rdy && do_issue) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy && (age[i] != {IDX_W{1'b1}})) age[i] <= age[i] + 1'b1;
            end
            age[free_idx] <= '0;
        end
    end

    rs_select #(.N(RS_SIZE)) u_pick (
        .eligible (elig_vec),
        .age      (age_flat),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    rs_select #(.N(RS_SIZE)) u_free (
        .eligible (~busy_vec),
        .age      ('0),
        .found    (free_found),
        .idx      (free_idx)
    );
`else
    rs_select #(.N(RS_SIZE)) u_pick (
        .eligible (elig_vec),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    rs_select #(.N(RS_SIZE)) u_free (
        .eligible (~busy_vec),
        .found    (free_found),
        .idx      (free_idx)
    );
`endif

    // Entry storage, wake-up, dispatch and issue; reset/rollback clear everything.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            alu_en  <= 1'b0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= 1'b0;
            val1    <= '0;
            val2    <= '0;
            imm     <= '0;
            pc      <= '0;
            rob_pos <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy) begin
                    ent[i].op1 <= snoop(ent[i].op1, alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
                    ent[i].op2 <= snoop(ent[i].op2, alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
                end
            end
            if (sel_found) begin
                ent[sel_idx].busy <= 1'b0;
                alu_en  <= 1'b1;
                opcode  <= ent[sel_idx].opcode;
                funct3  <= ent[sel_idx].funct3;
                funct7  <= ent[sel_idx].funct7;
                val1    <= ent[sel_idx].op1.val;
                val2    <= ent[sel_idx].op2.val;
                imm     <= ent[sel_idx].imm;
                pc      <= ent[sel_idx].pc;
                rob_pos <= ent[sel_idx].rob_pos;
            end else begin
                alu_en <= 1'b0;
            end
            if (do_issue) ent[free_idx] <= new_ent;
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
Reservation station for the ALU, on the issuing side of the RS→ALU interface.
- Buffers decoded ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) from the dispatcher.
- Snoops the ALU and LSB result broadcasts to wake up pending operands.
- Each cycle, selects one entry with both operands ready and drives the ALU issue port with registered signals.
- Sits between the dispatcher/ROB and the ALU.

Parameters:
- RS_SIZE, 16, number of entries; power of two, at least 2.
- ROB_POS_W, 4, width of the ROB tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds
- rollback  in  1  misprediction flush
- issue_valid  in  1  dispatcher writes one instruction this cycle
- issue_opcode  in  7  opcode
- issue_funct3  in  3  funct3
- issue_funct7  in  1  funct7 bit 30
- issue_rs1_val  in  32  operand 1 value; valid when issue_rs1_rdy=1
- issue_rs1_rdy  in  1  operand 1 available
- issue_rs1_tag  in  ROB_POS_W  producer ROB tag for operand 1; used when issue_rs1_rdy=0
- issue_rs2_val  in  32  operand 2 value
- issue_rs2_rdy  in  1  operand 2 available
- issue_rs2_tag  in  ROB_POS_W  producer ROB tag for operand 2
- issue_imm  in  32  immediate
- issue_pc  in  32  instruction address
- issue_rob_pos  in  ROB_POS_W  destination ROB entry
- rs_full  out  1  no free entry
- alu_result  in  1  ALU broadcast valid
- alu_result_rob_pos  in  ROB_POS_W  ALU broadcast tag
- alu_result_val  in  32  ALU broadcast value
- lsb_result  in  1  LSB broadcast valid
- lsb_result_rob_pos  in  ROB_POS_W  LSB broadcast tag
- lsb_result_val  in  32  LSB broadcast value
- alu_en  out  1  issue strobe to the ALU
- opcode  out  7  issued opcode
- funct3  out  3  issued funct3
- funct7  out  1  issued funct7 bit
- val1  out  32  issued operand 1
- val2  out  32  issued operand 2
- imm  out  32  issued immediate
- pc  out  32  issued instruction address
- rob_pos  out  ROB_POS_W  issued ROB tag

Behaviour:
- Reset, and the cycle after rollback: all entries cleared; alu_en=0. All other outputs reset to 0.
- rdy=0: no state or output changes. Issue, broadcasts and selection in that cycle are ignored; the sender must hold them.
- Each entry holds: busy, opcode, funct3, funct7, imm, pc, rob_pos, and for each operand a value, a ready bit and a tag.
- rs_full: combinational, high when all RS_SIZE entries are busy, evaluated before this cycle's dispatch.
  - The dispatcher must not assert issue_valid while rs_full=1.
  - If it does, the instruction is dropped; the bench flags this.
- Issue: written into the lowest-index free entry at the clock edge.
- Issue-time bypass: if an operand is not ready and its tag matches a valid same-cycle broadcast, the entry stores the broadcast value with ready=1.
- Wake-up, every busy entry, every edge: a non-ready operand whose tag equals a valid broadcast tag captures that value and sets ready.
  - If both broadcasts carry the same tag (illegal), the ALU broadcast wins.
- Selection: combinational over the state at the start of the cycle. An entry is eligible only when busy and both operands are ready.
  - An operand woken at edge N is eligible from the cycle after edge N.
- Dispatch: at the edge, the selected entry's fields are registered onto the ALU outputs, alu_en=1, and the entry's busy bit is cleared.
  - If nothing is eligible, alu_en=0 and the other outputs hold.
  - alu_en is a one-cycle strobe per dispatched instruction.
  - Back-to-back dispatch of one instruction per cycle is supported.
- Latency: an instruction issued with both operands ready at edge N has alu_en=1 after edge N+1.
- Issue and dispatch in the same cycle are allowed. A slot freed by dispatch is reusable from the next cycle.
- Operands are always passed through unmodified. The ALU chooses between val2 and imm.
- Rollback, when rdy=1: overrides issue, wake-up and dispatch in that cycle.
- Reset mid-operation: all in-flight entries are discarded; no alu_en follows.

Optional Feature:
- Macro: ALU_RS_OLDEST_FIRST_EN.
- Defined: selection picks the eligible entry issued earliest.
  - Each entry keeps an age counter of $clog2(RS_SIZE) bits.
  - The counter is set to 0 on issue and incremented each cycle while other entries issue, saturating.
  - Ties go to the lower index.
- Undefined: fixed priority, lowest eligible index; no age state.

Decomposition:
- Shared package (alongside the existing global defines):
  - ROB tag width.
  - Opcode constants OPCODE_ARITH/ARITHI/BR/JAL/JALR/LUI/AUIPC.
  - Entry struct or typedef: fields plus per-operand {val, rdy, tag}.
- Sub-module: rs_select.
  - Parameterized priority/age picker.
  - Input: eligible vector (and ages under the macro).
  - Outputs: found flag and index.
  - Reused later by the LSB.

Test Plan:
- Issue ADDI, rs1 ready (val 5, imm 3), at edge 0 → alu_en=1 after edge 1 with val1=5, imm=3, rob_pos as issued; entry freed.
- Issue ADD with rs2 not ready (tag 7); ALU broadcast tag 7, val 0x10 two cycles later → alu_en the cycle after the wake edge, val2=0x10.
- Issue with rs1 tag 3 in the same cycle as LSB broadcast tag 3, val 0xAB → bypass captured; dispatch next edge with val1=0xAB.
- Fill 16 entries, all waiting on tag 9 → rs_full=1. Broadcast tag 9 → 16 consecutive alu_en cycles.
  - Default: index order 0..15.
  - With ALU_RS_OLDEST_FIRST_EN: issue order.
- 4 waiting entries, then rollback=1 → alu_en=0 next cycle, rs_full=0. A later broadcast of their tags produces no dispatch.
- rdy=0 for 3 cycles with 2 ready entries → no alu_en and state held. Dispatch resumes on the first cycle with rdy=1.
